mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port line-fill arbiter and sequencer in front of the shared word-wide main memory. Accepts cache-line read requests from the instruction cache and the data cache, grants one at a time by round-robin, and issues LINE_WORDS consecutive word requests to memory. It assembles the returned words into a line and returns the line to the granted cache with a one-cycle response pulse. It sits between the two cache fill engines and the memory model.

## Interface
- LINE_WORDS, 4, words per cache line; power of two, 1..8
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous reset, active-low
- icache_req  input  1  instruction-cache fill request; held high with stable addr until icache_resp
- icache_addr  input  32  byte address of the missing line; low log2(LINE_WORDS)+2 bits ignored
- icache_resp  output  1  one-cycle pulse: fill complete, icache_line valid this cycle
- icache_line  output  32*LINE_WORDS  filled line, word k at bits [32k+31:32k]
- dcache_req / dcache_addr / dcache_resp / dcache_line  same as icache_* for the data cache
- mem_req  output  1  word request to memory; held high until mem_resp
- mem_addr  output  32  word-aligned byte address to memory
- mem_resp  input  1  one-cycle pulse: mem_data valid this cycle
- mem_data  input  32  read data from memory

## Operation
- States: IDLE, FILL, DONE. Registers: state, grant (I/D), last_grant, base[31:0], cnt[log2(LINE_WORDS):0], line buffer.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the port that is not last_grant.
  - On a grant: base = granted addr with low log2(LINE_WORDS)+2 bits cleared, cnt = 0, go to FILL.
  - If no req is high, stay in IDLE.
- FILL:
  - mem_req = 1, mem_addr = base + (cnt << 2), driven combinationally from registers.
  - On mem_resp: line word[cnt] <= mem_data.
  - If cnt == LINE_WORDS-1, go to DONE. Otherwise cnt <= cnt+1, and mem_req stays high with the new address from the next cycle.
- DONE:
  - The granted port's resp = 1 for exactly one cycle. The other port's resp stays 0.
  - last_grant <= grant, go to IDLE.
- Line buffer is shared. icache_line and dcache_line both drive from it and are meaningful only while the matching resp is high. The buffer holds its value until overwritten by the next fill.
- Outside FILL: mem_req = 0, mem_addr = 0.
- mem_resp outside FILL is ignored.
- Address arithmetic is 32-bit. base is line-aligned, so base + (cnt<<2) never carries out of the line.
- A requester dropping req mid-fill does not abort the fill. The fill completes and resp still pulses.
- A req still high in the cycle after its resp is a new request and is arbitrated in that IDLE cycle.
- Reset (asynchronous, any state):
  - state = IDLE, cnt = 0, base = 0, line buffer = 0.
  - last_grant = I, so D wins the first tie.
  - mem_req, mem_addr, icache_resp and dcache_resp all go to 0 immediately.
  - An interrupted fill is lost; the memory sees mem_req drop.

## Timing
- Request sampled in IDLE at cycle T. FILL and mem_req begin at T+1.
- Memory word latency L is counted from the first cycle mem_req is high to the mem_resp cycle inclusive. The current memory model gives L = 11.
- Word k response at T + (k+1)*L.
- resp pulse at T + LINE_WORDS*L + 1. For LINE_WORDS=4 and L=11, resp is at T+45.
- Back-to-back fills: next IDLE arbitration at resp cycle + 1. Minimum gap between fills is one IDLE cycle.
- mem_req stays continuously high across all words of a line. It drops for the DONE and IDLE cycles.
- No combinational path from any req or addr input to mem_req or mem_addr. mem_resp affects only registered state.

## Test plan
- Single icache fill: icache_addr=0x0000_0014, LINE_WORDS=4, memory words 0x0..0xF = 0xA0+k.
  - Required: mem_addr sequence 0x10, 0x14, 0x18, 0x1C.
  - Required: icache_resp at T+45 for one cycle, icache_line = {0xA7,0xA6,0xA5,0xA4}.
  - Required: dcache_resp stays 0.
- Simultaneous requests after reset: both req high at T.
  - Required: dcache served first and dcache_resp at T+45.
  - Required: icache granted at T+46, resp at T+91.
- Round-robin fairness: both requesters re-request immediately after each resp for 6 fills.
  - Required: grants alternate D, I, D, I, D, I.
- Reset mid-fill: assert rst_n=0 during the 2nd word of a dcache fill.
  - Required: mem_req=0 and dcache_resp=0 in the same cycle.
  - Required: after release with dcache_req held, a fresh fill restarts from word 0 of the same line.
- Requester drops req after 1 cycle with a stray mem_resp injected while IDLE.
  - Required: the fill still completes and pulses resp.
  - Required: the stray mem_resp causes no state change and no buffer write.
- LINE_WORDS=1, addr=0xFFFF_FFFC.
  - Required: single mem_addr 0xFFFF_FFFC, resp at T+L+1, no wrap fault.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin line-fill arbiter: grants one cache at a time, fetches
// LINE_WORDS consecutive words from memory and returns the assembled line.
module mem_arbiter #(
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    icache_req,
  input  logic [31:0]             icache_addr,
  output logic                    icache_resp,
  output logic [32*LINE_WORDS-1:0] icache_line,
  input  logic                    dcache_req,
  input  logic [31:0]             dcache_addr,
  output logic                    dcache_resp,
  output logic [32*LINE_WORDS-1:0] dcache_line,
  output logic                    mem_req,
  output logic [31:0]             mem_addr,
  input  logic                    mem_resp,
  input  logic [31:0]             mem_data
);

  localparam int unsigned IDXW = $clog2(LINE_WORDS);
  localparam int unsigned CNTW = IDXW + 1;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << (IDXW + 2)) - 32'd1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;
  typedef enum logic {PORT_I, PORT_D} port_e;

  state_e                  state_q;
  port_e                   grant_q;
  port_e                   last_grant_q;
  logic [31:0]             base_q;
  logic [CNTW-1:0]         cnt_q;
  logic [32*LINE_WORDS-1:0] line_q;
  logic                    icache_resp_q;
  logic                    dcache_resp_q;

  logic                    arb_valid;
  port_e                   arb_port;
  logic [31:0]             arb_base;

  // On a tie the port that was not served last wins.
  always_comb begin
    arb_valid = icache_req | dcache_req;
    if (icache_req && dcache_req) begin
      arb_port = (last_grant_q == PORT_I) ? PORT_D : PORT_I;
    end else begin
      arb_port = dcache_req ? PORT_D : PORT_I;
    end
    arb_base = ((arb_port == PORT_D) ? dcache_addr : icache_addr) & LINE_MASK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= PORT_I;
      last_grant_q  <= PORT_I;
      base_q        <= '0;
      cnt_q         <= '0;
      line_q        <= '0;
      icache_resp_q <= 1'b0;
      dcache_resp_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          icache_resp_q <= 1'b0;
          dcache_resp_q <= 1'b0;
          if (arb_valid) begin
            grant_q <= arb_port;
            base_q  <= arb_base;
            cnt_q   <= '0;
            state_q <= FILL;
          end
        end
        FILL: begin
          if (mem_resp) begin
            for (int unsigned k = 0; k < LINE_WORDS; k++) begin
              if (cnt_q == CNTW'(k)) line_q[32*k +: 32] <= mem_data;
            end
            // Response pulse is registered on the way into DONE.
            if (cnt_q == CNT_LAST) begin
              icache_resp_q <= (grant_q == PORT_I);
              dcache_resp_q <= (grant_q == PORT_D);
              state_q       <= DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          icache_resp_q <= 1'b0;
          dcache_resp_q <= 1'b0;
          last_grant_q  <= grant_q;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req  = (state_q == FILL);
    mem_addr = mem_req ? (base_q + (32'(cnt_q) << 2)) : '0;
  end

  assign icache_resp = icache_resp_q;
  assign dcache_resp = dcache_resp_q;
  assign icache_line = line_q;
  assign dcache_line = line_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-plus-random bench for mem_arbiter with a fixed-latency memory model
// and a line/address/timing reference computed from the arbitration rules.
module tb_mem_arbiter;

  localparam int L = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: LINE_WORDS=4
  logic         ireq_a, dreq_a, iresp_a, dresp_a, mreq_a, mresp_a;
  logic [31:0]  iaddr_a, daddr_a, maddr_a, mdata_a;
  logic [127:0] iline_a, dline_a;
  // DUT B: LINE_WORDS=1
  logic         ireq_b, dreq_b, iresp_b, dresp_b, mreq_b, mresp_b;
  logic [31:0]  iaddr_b, daddr_b, maddr_b, mdata_b;
  logic [31:0]  iline_b, dline_b;

  mem_arbiter #(.LINE_WORDS(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .icache_req(ireq_a), .icache_addr(iaddr_a), .icache_resp(iresp_a), .icache_line(iline_a),
    .dcache_req(dreq_a), .dcache_addr(daddr_a), .dcache_resp(dresp_a), .dcache_line(dline_a),
    .mem_req(mreq_a), .mem_addr(maddr_a), .mem_resp(mresp_a), .mem_data(mdata_a)
  );

  mem_arbiter #(.LINE_WORDS(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .icache_req(ireq_b), .icache_addr(iaddr_b), .icache_resp(iresp_b), .icache_line(iline_b),
    .dcache_req(dreq_b), .dcache_addr(daddr_b), .dcache_resp(dresp_b), .dcache_line(dline_b),
    .mem_req(mreq_b), .mem_addr(maddr_b), .mem_resp(mresp_b), .mem_data(mdata_b)
  );

  logic [31:0] mem [256];
  logic [31:0] alog[$];
  logic [31:0] blog[$];
  int lat_a = 0, lat_b = 0;
  int stray_req = 0, stray_done = 0;
  int icnt_a = 0, dcnt_a = 0;
  int checks = 0, failures = 0;

  // Memory: answers the L-th consecutive cycle of mem_req; optional stray pulse.
  always @(negedge clk) begin
    mresp_a = 1'b0;
    if (stray_req != stray_done) begin
      stray_done++;
      mresp_a = 1'b1;
      mdata_a = 32'hDEADBEEF;
    end else if (mreq_a) begin
      lat_a++;
      if (lat_a == L) begin
        lat_a   = 0;
        mresp_a = 1'b1;
        mdata_a = mem[maddr_a[9:2]];
        alog.push_back(maddr_a);
      end
    end else begin
      lat_a = 0;
    end
  end

  always @(negedge clk) begin
    mresp_b = 1'b0;
    if (mreq_b) begin
      lat_b++;
      if (lat_b == L) begin
        lat_b   = 0;
        mresp_b = 1'b1;
        mdata_b = mem[maddr_b[9:2]];
        blog.push_back(maddr_b);
      end
    end else begin
      lat_b = 0;
    end
  end

  always @(negedge clk) begin
    if (iresp_a) icnt_a++;
    if (dresp_a) dcnt_a++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  function automatic logic [127:0] model_line(input logic [31:0] addr, input int unsigned lw);
    logic [127:0] r;
    logic [31:0]  base;
    logic [7:0]   idx;
    r = '0;
    base = addr - (addr % (lw * 4));
    for (int unsigned k = 0; k < lw; k++) begin
      idx = 8'((base / 4) + k);
      r[32*k +: 32] = mem[idx];
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] addr, input int unsigned lw,
                                           input int unsigned k);
    return addr - (addr % (lw * 4)) + 4 * k;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_resp(input bit on_b, output bit d, output int at, output logic [127:0] line);
    bit got;
    got = 1'b0; d = 1'b0; at = -1; line = '0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk); #1;
      if (on_b) begin
        if (iresp_b || dresp_b) begin
          got = 1'b1; d = dresp_b; at = cyc;
          line = {96'b0, dresp_b ? dline_b : iline_b};
        end
      end else if (iresp_a || dresp_a) begin
        got = 1'b1; d = dresp_a; at = cyc;
        line = dresp_a ? dline_a : iline_a;
        check("resp_exclusive", iresp_a & dresp_a, 0);
      end
    end
    if (!got) check("resp_timeout", got, 1);
  endtask

  task automatic check_alog(input string tag, input int mark, input logic [31:0] addr);
    check({tag, "_nwords"}, alog.size() - mark, 4);
    if (alog.size() - mark == 4)
      for (int k = 0; k < 4; k++) check({tag, "_addr"}, alog[mark+k], exp_addr(addr, 4, k));
  endtask

  task automatic do_reset();
    ireq_a = 0; dreq_a = 0; ireq_b = 0; dreq_b = 0;
    rst_n = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk); #1;
  endtask

  initial begin
    int T, at, mark, ic0, dc0, prev;
    bit d, exp_d;
    logic [127:0] ln, ln0;
    logic [31:0] a_i, a_d;

    ireq_a = 0; dreq_a = 0; iaddr_a = '0; daddr_a = '0;
    ireq_b = 0; dreq_b = 0; iaddr_b = '0; daddr_b = '0;
    for (int k = 0; k < 256; k++) mem[k] = (k < 16) ? 32'hA0 + k : $urandom;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req", mreq_a, 0);
    check("rst_mem_addr", maddr_a, 0);
    check("rst_iresp", iresp_a, 0);
    check("rst_dresp", dresp_a, 0);
    check("rst_line", iline_a, 0);
    do_reset();

    // Single icache fill
    mark = alog.size(); dc0 = dcnt_a;
    iaddr_a = 32'h0000_0014; ireq_a = 1; T = cyc;
    wait_resp(0, d, at, ln);
    ireq_a = 0;
    check("t1_port", d, 0);
    check("t1_cycle", at, T + 45);
    check("t1_line", ln, 128'h000000A7_000000A6_000000A5_000000A4);
    check_alog("t1", mark, 32'h14);
    @(negedge clk); #1;
    check("t1_pulse_width", iresp_a, 0);
    check("t1_memreq_idle", mreq_a, 0);
    check("t1_no_dresp", dcnt_a - dc0, 0);

    // Simultaneous requests after reset: D first
    do_reset();
    a_i = $urandom; a_d = $urandom;
    iaddr_a = a_i; daddr_a = a_d; mark = alog.size();
    ireq_a = 1; dreq_a = 1; T = cyc;
    wait_resp(0, d, at, ln);
    dreq_a = 0;
    check("t2_first_port", d, 1);
    check("t2_first_cycle", at, T + 45);
    check("t2_first_line", ln, model_line(a_d, 4));
    wait_resp(0, d, at, ln);
    ireq_a = 0;
    check("t2_second_port", d, 0);
    check("t2_second_cycle", at, T + 91);
    check("t2_second_line", ln, model_line(a_i, 4));
    check("t2_nwords", alog.size() - mark, 8);
    if (alog.size() - mark == 8)
      for (int k = 0; k < 4; k++) begin
        check("t2_daddr", alog[mark+k], exp_addr(a_d, 4, k));
        check("t2_iaddr", alog[mark+4+k], exp_addr(a_i, 4, k));
      end

    // Round-robin fairness over 6 fills
    do_reset();
    a_i = $urandom; a_d = $urandom;
    iaddr_a = a_i; daddr_a = a_d;
    ireq_a = 1; dreq_a = 1; T = cyc; exp_d = 1; prev = 0;
    for (int f = 0; f < 6; f++) begin
      wait_resp(0, d, at, ln);
      check("t3_port", d, exp_d);
      check("t3_cycle", at, (f == 0) ? T + 45 : prev + 46);
      check("t3_line", ln, model_line(exp_d ? a_d : a_i, 4));
      prev = at;
      if (d) begin a_d = $urandom; daddr_a = a_d; end
      else   begin a_i = $urandom; iaddr_a = a_i; end
      exp_d = !exp_d;
    end
    ireq_a = 0; dreq_a = 0;
    @(negedge clk); #1;
    check("t3_idle_memreq", mreq_a, 0);

    // Reset during the second word of a dcache fill
    do_reset();
    a_d = $urandom; daddr_a = a_d; mark = alog.size();
    dreq_a = 1; T = cyc;
    repeat (15) @(negedge clk);
    rst_n = 0;
    #1;
    check("t4_rst_memreq", mreq_a, 0);
    check("t4_rst_memaddr", maddr_a, 0);
    check("t4_rst_dresp", dresp_a, 0);
    check("t4_words_before", alog.size() - mark, 1);
    @(negedge clk);
    rst_n = 1;
    #1;
    T = cyc; mark = alog.size();
    wait_resp(0, d, at, ln);
    dreq_a = 0;
    check("t4_port", d, 1);
    check("t4_cycle", at, T + 45);
    check("t4_line", ln, model_line(a_d, 4));
    check_alog("t4", mark, a_d);

    // Stray mem_resp while IDLE, then a one-cycle request
    @(negedge clk); #1;
    ln0 = iline_a; ic0 = icnt_a; dc0 = dcnt_a;
    stray_req++;
    repeat (3) @(negedge clk);
    #1;
    check("t5_stray_line", iline_a, ln0);
    check("t5_stray_memreq", mreq_a, 0);
    check("t5_stray_resp", (icnt_a - ic0) + (dcnt_a - dc0), 0);
    a_i = $urandom; iaddr_a = a_i; mark = alog.size();
    ireq_a = 1; T = cyc;
    @(negedge clk); #1;
    ireq_a = 0;
    wait_resp(0, d, at, ln);
    check("t5_port", d, 0);
    check("t5_cycle", at, T + 45);
    check("t5_line", ln, model_line(a_i, 4));
    check_alog("t5", mark, a_i);
    @(negedge clk); #1;
    check("t5_no_refill", mreq_a, 0);

    // LINE_WORDS=1 at the top of the address space
    mark = blog.size();
    iaddr_b = 32'hFFFF_FFFC; ireq_b = 1; T = cyc;
    wait_resp(1, d, at, ln);
    ireq_b = 0;
    check("t6_port", d, 0);
    check("t6_cycle", at, T + L + 1);
    check("t6_line", ln, model_line(32'hFFFF_FFFC, 1));
    check("t6_nwords", blog.size() - mark, 1);
    if (blog.size() - mark == 1) check("t6_addr", blog[mark], 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check("t6_idle_memreq", mreq_b, 0);
    check("t6_idle_memaddr", maddr_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
